// File: rtl/dzcpu_interrupt_ctrl_pkg.sv
// Shared constants and types for the dzcpu interrupt controller.
// The flow index default is also referenced by the ucode LUT/ROM entries.
package dzcpu_interrupt_ctrl_pkg;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    localparam logic [7:0]  INT_FLOW_IDX_DEF = 8'd171;
    localparam logic [15:0] VECTOR_BASE_DEF  = 16'h0040;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_t;

    // Sources sit 8 bytes apart starting at the base vector.
    function automatic logic [15:0] int_vector(input logic [15:0] base, input logic [2:0] idx);
        return base + {10'b0, idx, 3'b000};
    endfunction

endpackage

// File: rtl/dzcpu_int_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins (VBlank highest).
module dzcpu_int_prio_enc
    import dzcpu_interrupt_ctrl_pkg::*;
(
    input  logic [4:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        if (req[INT_VBLANK])      idx = 3'(INT_VBLANK);
        else if (req[INT_STAT])   idx = 3'(INT_STAT);
        else if (req[INT_TIMER])  idx = 3'(INT_TIMER);
        else if (req[INT_SERIAL]) idx = 3'(INT_SERIAL);
        else if (req[INT_JOYPAD]) idx = 3'(INT_JOYPAD);
    end

endmodule

// File: rtl/dzcpu_interrupt_ctrl.sv
// dzcpu interrupt controller: IE/IF registers, IME with EI delay, and the
// dispatch handshake with the microcode sequencer.
//
// state   | meaning
// IDLE    | no dispatch in progress
// REQ     | requesting the interrupt-entry flow, vector follows arbitration
// SERVICE | entry flow running, vector frozen on the acknowledged source
module dzcpu_interrupt_ctrl
    import dzcpu_interrupt_ctrl_pkg::*;
#(
    parameter logic [7:0]  INT_FLOW_IDX = INT_FLOW_IDX_DEF,
    parameter logic [15:0] VECTOR_BASE  = VECTOR_BASE_DEF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [4:0]  iIntReq,
    input  logic [15:0] iMcuAddr,
    input  logic        iMcuWe,
    input  logic [7:0]  iMcuData,
    output logic [7:0]  oMcuData,
    output logic        oMcuHit,
    input  logic        iEi,
    input  logic        iDi,
    input  logic        iReti,
    input  logic        iInstrBoundary,
    input  logic        iIntAck,
    input  logic        iFlowDone,
    output logic        oIntPending,
    output logic [7:0]  oFlowIdx,
    output logic [15:0] oVector,
    output logic        oIme,
    output logic        oHaltWake
);

    logic [7:0]  ie_q;
    logic [7:0]  ie_d;
    logic [4:0]  if_q;
    logic [4:0]  if_d;
    logic        ime_q;
    logic        ime_d;
    logic        ei_pend_q;
    logic        ei_pend_d;
    logic [2:0]  src_q;
    logic [2:0]  src_d;
    int_state_t  state_q;
    int_state_t  state_d;

    logic [4:0]  active;
    logic [2:0]  win_idx;
    logic        win_valid;
    logic        ack_take;
    logic        sel_if;
    logic        sel_ie;

    assign active = ie_q[4:0] & if_q;

    dzcpu_int_prio_enc u_prio_enc (
        .req   (active),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign sel_if = (iMcuAddr == ADDR_IF);
    assign sel_ie = (iMcuAddr == ADDR_IE);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ime_q && win_valid && !ei_pend_q)
                    state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!win_valid || !ime_q) begin
                    state_d = ST_IDLE;
                end else if (iIntAck) begin
                    ack_take = 1'b1;
                    src_d    = win_idx;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (iFlowDone)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write, then ack clear, then hardware set: a new request is never lost.
    always_comb begin
        if_d = if_q;
        if (iMcuWe && sel_if)
            if_d = iMcuData[4:0];
        if (ack_take)
            if_d[win_idx] = 1'b0;
        if_d = if_d | iIntReq;
    end

    always_comb begin
        ie_d = ie_q;
        if (iMcuWe && sel_ie)
            ie_d = iMcuData;
    end

    // An EI on a boundary cycle only arms; the next boundary enables.
    always_comb begin
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        if (ack_take || iDi) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end else if (iReti) begin
            ime_d = 1'b1;
        end else begin
            if (ei_pend_q && iInstrBoundary) begin
                ime_d     = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (iEi)
                ei_pend_d = 1'b1;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            ie_q      <= 8'h00;
            if_q      <= 5'h00;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            src_q     <= 3'd0;
            state_q   <= ST_IDLE;
        end else begin
            ie_q      <= ie_d;
            if_q      <= if_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            src_q     <= src_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        oMcuHit  = sel_if || sel_ie;
        oMcuData = 8'h00;
        if (sel_if)
            oMcuData = {3'b111, if_q};
        else if (sel_ie)
            oMcuData = ie_q;
    end

    always_comb begin
        oIntPending = (state_q == ST_REQ);
        oFlowIdx    = oIntPending ? INT_FLOW_IDX : 8'h00;
        if (state_q == ST_SERVICE)
            oVector = int_vector(VECTOR_BASE, src_q);
        else
            oVector = int_vector(VECTOR_BASE, win_idx);
        oIme      = ime_q;
        oHaltWake = |active;
    end

endmodule

// File: tb/tb_dzcpu_interrupt_ctrl.sv
// Directed bench for dzcpu_interrupt_ctrl; expectations are queued when
// stimulus is applied and compared when the DUT output is sampled.
module tb_dzcpu_interrupt_ctrl;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic [4:0]  iIntReq = 5'h00;
    logic [15:0] iMcuAddr = 16'h0000;
    logic        iMcuWe = 1'b0;
    logic [7:0]  iMcuData = 8'h00;
    logic [7:0]  oMcuData;
    logic        oMcuHit;
    logic        iEi = 1'b0;
    logic        iDi = 1'b0;
    logic        iReti = 1'b0;
    logic        iInstrBoundary = 1'b0;
    logic        iIntAck = 1'b0;
    logic        iFlowDone = 1'b0;
    logic        oIntPending;
    logic [7:0]  oFlowIdx;
    logic [15:0] oVector;
    logic        oIme;
    logic        oHaltWake;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    dzcpu_interrupt_ctrl dut (
        .iClock         (iClock),
        .iReset         (iReset),
        .iIntReq        (iIntReq),
        .iMcuAddr       (iMcuAddr),
        .iMcuWe         (iMcuWe),
        .iMcuData       (iMcuData),
        .oMcuData       (oMcuData),
        .oMcuHit        (oMcuHit),
        .iEi            (iEi),
        .iDi            (iDi),
        .iReti          (iReti),
        .iInstrBoundary (iInstrBoundary),
        .iIntAck        (iIntAck),
        .iFlowDone      (iFlowDone),
        .oIntPending    (oIntPending),
        .oFlowIdx       (oFlowIdx),
        .oVector        (oVector),
        .oIme           (oIme),
        .oHaltWake      (oHaltWake)
    );

    always #5 iClock = ~iClock;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        iMcuAddr = addr;
        iMcuData = data;
        iMcuWe   = 1'b1;
        tick();
        iMcuWe   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] e);
        expect_v({8'h00, e});
        iMcuAddr = addr;
        #1;
        check(tag, {8'h00, oMcuData});
    endtask

    task automatic pulse_ei();       iEi = 1'b1;            tick(); iEi = 1'b0;            endtask
    task automatic pulse_di();       iDi = 1'b1;            tick(); iDi = 1'b0;            endtask
    task automatic pulse_reti();     iReti = 1'b1;          tick(); iReti = 1'b0;          endtask
    task automatic pulse_boundary(); iInstrBoundary = 1'b1; tick(); iInstrBoundary = 1'b0; endtask
    task automatic pulse_ack();      iIntAck = 1'b1;        tick(); iIntAck = 1'b0;        endtask
    task automatic pulse_done();     iFlowDone = 1'b1;      tick(); iFlowDone = 1'b0;      endtask
    task automatic pulse_req(input logic [4:0] r); iIntReq = r; tick(); iIntReq = 5'h00;   endtask

    initial begin
        // Reset
        iReset = 1'b0;
        tick();
        tick();
        iReset = 1'b1;
        rd_chk("rst_if", 16'hFF0F, 8'hE0);
        rd_chk("rst_ie", 16'hFFFF, 8'h00);
        expect_v(16'h0); check("rst_pending", {15'b0, oIntPending});
        expect_v(16'h0); check("rst_ime", {15'b0, oIme});
        expect_v(16'h0040); check("rst_vector", oVector);
        expect_v(16'h0); check("rst_halt", {15'b0, oHaltWake});
        expect_v(16'h1); iMcuAddr = 16'hFF0F; #1; check("hit_if", {15'b0, oMcuHit});
        expect_v(16'h0); iMcuAddr = 16'hFF10; #1; check("miss_data", {8'h00, oMcuData});

        // Basic VBlank dispatch after EI
        wr(16'hFFFF, 8'h01);
        pulse_ei();
        expect_v(16'h0); check("ei_not_yet", {15'b0, oIme});
        pulse_boundary();
        pulse_boundary();
        expect_v(16'h1); check("ime_after_ei", {15'b0, oIme});
        pulse_req(5'b00001);
        expect_v(16'h0); check("lat_1cyc", {15'b0, oIntPending});
        tick();
        expect_v(16'h1); check("lat_2cyc", {15'b0, oIntPending});
        expect_v(16'h0040); check("vec_vblank", oVector);
        expect_v(16'd171); check("flow_idx", {8'h00, oFlowIdx});
        pulse_ack();
        rd_chk("ack_if_clr", 16'hFF0F, 8'hE0);
        expect_v(16'h0); check("ack_ime", {15'b0, oIme});
        expect_v(16'h0); check("svc_pending", {15'b0, oIntPending});
        expect_v(16'h0); check("svc_flowidx", {8'h00, oFlowIdx});
        pulse_done();

        // Priority: Timer before Joypad, then Joypad after RETI
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h14);
        pulse_reti();
        expect_v(16'h0); check("reti_idle", {15'b0, oIntPending});
        tick();
        expect_v(16'h1); check("timer_pend", {15'b0, oIntPending});
        expect_v(16'h0050); check("vec_timer", oVector);
        pulse_ack();
        expect_v(16'h0050); check("vec_frozen", oVector);
        rd_chk("if_after_timer", 16'hFF0F, 8'hF0);
        pulse_done();
        pulse_reti();
        tick();
        expect_v(16'h1); check("joy_pend", {15'b0, oIntPending});
        expect_v(16'h0060); check("vec_joypad", oVector);
        pulse_ack();
        pulse_done();

        // EI delay: request in the EI cycle waits for the next boundary
        iEi = 1'b1; iIntReq = 5'b00001;
        tick();
        iEi = 1'b0; iIntReq = 5'h00;
        tick();
        tick();
        expect_v(16'h0); check("ei_delay_pend", {15'b0, oIntPending});
        expect_v(16'h0); check("ei_delay_ime", {15'b0, oIme});
        pulse_boundary();
        expect_v(16'h1); check("ei_bnd_ime", {15'b0, oIme});
        tick();
        expect_v(16'h1); check("ei_bnd_pend", {15'b0, oIntPending});
        pulse_ack();
        pulse_done();

        // EI on a boundary cycle does not count that boundary
        iEi = 1'b1; iInstrBoundary = 1'b1;
        tick();
        iEi = 1'b0; iInstrBoundary = 1'b0;
        expect_v(16'h0); check("ei_on_bnd", {15'b0, oIme});
        pulse_di();

        // DI before the boundary cancels the pending EI
        pulse_ei();
        pulse_req(5'b00001);
        pulse_di();
        pulse_boundary();
        pulse_boundary();
        expect_v(16'h0); check("di_cancel_ime", {15'b0, oIme});
        expect_v(16'h0); check("di_cancel_pend", {15'b0, oIntPending});
        wr(16'hFF0F, 8'h00);

        // Hardware set wins over same-cycle write clear
        iIntReq = 5'b00100;
        wr(16'hFF0F, 8'h00);
        iIntReq = 5'h00;
        rd_chk("set_wins", 16'hFF0F, 8'hE4);
        pulse_reti();
        tick();
        expect_v(16'h1); check("req_again", {15'b0, oIntPending});
        wr(16'hFF0F, 8'h00);
        tick();
        expect_v(16'h0); check("drop_on_clear", {15'b0, oIntPending});
        expect_v(16'h1); check("ime_kept", {15'b0, oIme});

        // iIntAck in IDLE is ignored
        pulse_ack();
        expect_v(16'h1); check("ack_idle_ign", {15'b0, oIme});

        // Reset while in SERVICE
        wr(16'hFF0F, 8'h01);
        tick();
        pulse_ack();
        expect_v(16'h0); check("svc2_pend", {15'b0, oIntPending});
        iReset = 1'b0;
        tick();
        iReset = 1'b1;
        expect_v(16'h0); check("rst2_pend", {15'b0, oIntPending});
        expect_v(16'h0); check("rst2_ime", {15'b0, oIme});
        expect_v(16'h0040); check("rst2_vec", oVector);
        expect_v(16'h0); check("rst2_flow", {8'h00, oFlowIdx});
        rd_chk("rst2_ie", 16'hFFFF, 8'h00);

        // Halt wake independent of IME
        wr(16'hFF0F, 8'h01);
        expect_v(16'h0); check("halt_ie0", {15'b0, oHaltWake});
        wr(16'hFFFF, 8'h01);
        expect_v(16'h1); check("halt_ie1", {15'b0, oHaltWake});
        expect_v(16'h0); check("halt_ime", {15'b0, oIme});
        tick();
        expect_v(16'h0); check("halt_nopend", {15'b0, oIntPending});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
